// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, state codes,
// datapath mux selects and the packed control word.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEXE  = 4'd6,
      S_RTWB   = 4'd7,
      S_IEXE   = 4'd8,
      S_IWB    = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11,
      S_JAL_WB = 4'd12
   } state_t;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;
   localparam logic [1:0] ALU_OR    = 2'd3;

   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   localparam logic [1:0] EXT_ZERO = 2'd0;
   localparam logic [1:0] EXT_SIGN = 2'd1;
   localparam logic [1:0] EXT_LUI  = 2'd2;

   localparam logic [1:0] SRCB_B    = 2'd0;
   localparam logic [1:0] SRCB_4    = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;
   localparam logic [1:0] SRCB_IMM2 = 2'd3;

   typedef struct packed {
      logic       ir_wr;
      logic       pc_en;
      logic       iord;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_wr;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] ext_op;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       illegal_op;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   function automatic logic is_known_op(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ORI,
         OP_ADDIU, OP_LUI, OP_J, OP_JAL: is_known_op = 1'b1;
         default:                        is_known_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_outdec.sv
// Control-word decoder: maps current state (plus opcode, zero flag and memory
// ready) onto the datapath control signals. Purely combinational.
module mc_outdec
   import mips_ctrl_pkg::*;
(
   input  logic [3:0]        state,
   input  logic [5:0]        opcode,
   input  logic              zero,
   input  logic              mem_rdy,
   output logic [CTRL_W-1:0] ctrl_word
);

   ctrl_t c;

   always_comb begin
      c = '0;
      case (state_t'(state))
         S_FETCH: begin
            c.mem_rd    = 1'b1;
            c.alu_src_b = SRCB_4;
            c.ir_wr     = mem_rdy;
            c.pc_en     = mem_rdy;
         end
         S_DECODE: begin
            // speculative branch target lands in ALUOut
            c.alu_src_b  = SRCB_IMM2;
            c.ext_op     = EXT_SIGN;
            c.illegal_op = !is_known_op(opcode);
         end
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.ext_op    = EXT_SIGN;
         end
         S_MEMRD: begin
            c.mem_rd = 1'b1;
            c.iord   = 1'b1;
         end
         S_MEMWB: begin
            c.reg_wr     = 1'b1;
            c.reg_dst    = DST_RT;
            c.mem_to_reg = M2R_MDR;
         end
         S_MEMWR: begin
            c.mem_wr = 1'b1;
            c.iord   = 1'b1;
         end
         S_RTEXE: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.alu_op    = ALU_FUNCT;
         end
         S_RTWB: begin
            c.reg_wr  = 1'b1;
            c.reg_dst = DST_RD;
         end
         S_IEXE: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            case (opcode)
               OP_ORI: begin
                  c.ext_op = EXT_ZERO;
                  c.alu_op = ALU_OR;
               end
               OP_LUI: begin
                  c.ext_op = EXT_LUI;
                  c.alu_op = ALU_OR;
               end
               default: begin
                  c.ext_op = EXT_SIGN;
                  c.alu_op = ALU_ADD;
               end
            endcase
         end
         S_IWB: begin
            c.reg_wr  = 1'b1;
            c.reg_dst = DST_RT;
         end
         S_BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.alu_op    = ALU_SUB;
            c.pc_src    = PC_ALUOUT;
            c.pc_en     = zero;
         end
         S_JUMP: begin
            c.pc_src = PC_JUMP;
            c.pc_en  = 1'b1;
         end
         S_JAL_WB: begin
            c.reg_wr     = 1'b1;
            c.reg_dst    = DST_RA;
            c.mem_to_reg = M2R_PC;
            c.pc_src     = PC_JUMP;
            c.pc_en      = 1'b1;
         end
         default: ;
      endcase
   end

   assign ctrl_word = c;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register and next-state logic; the
// control word comes from mc_outdec so outputs follow state during reset.
//
//  state  | meaning
//  FETCH  | read instruction at PC, PC+4 (waits on mem_ready)
//  DECODE | register read, branch target into ALUOut
//  MEMADR | effective address for LW/SW
//  MEMRD  | data read at ALUOut (waits on mem_ready)
//  MEMWB  | MDR -> rt
//  MEMWR  | data write at ALUOut (waits on mem_ready)
//  RTEXE  | A op B per funct
//  RTWB   | ALUOut -> rd
//  IEXE   | A op extended immediate
//  IWB    | ALUOut -> rt
//  BRANCH | compare A/B, take ALUOut if zero
//  JUMP   | PC <- jump target
//  JAL_WB | $31 <- PC, PC <- jump target
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_EN = 1,
   parameter int ST_W        = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [5:0]      opcode,
   input  logic [5:0]      funct,
   input  logic            zero,
   input  logic            mem_ready,
   output logic            ir_wr,
   output logic            pc_en,
   output logic            iord,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            reg_wr,
   output logic [1:0]      reg_dst,
   output logic [1:0]      mem_to_reg,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      ext_op,
   output logic [1:0]      alu_op,
   output logic [1:0]      pc_src,
   output logic            illegal_op,
   output logic [ST_W-1:0] state
);

   state_t            state_q, state_d;
   logic              rdy;
   logic [CTRL_W-1:0] ctrl_word;
   ctrl_t             ctrl;
   logic              unused_funct;

   // aludec decodes funct itself; this block only passes alu_op through
   assign unused_funct = ^funct;

   assign rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:             state_d = S_MEMADR;
               OP_RTYPE:                 state_d = S_RTEXE;
               OP_BEQ:                   state_d = S_BRANCH;
               OP_ORI, OP_ADDIU, OP_LUI: state_d = S_IEXE;
               OP_J:                     state_d = S_JUMP;
               OP_JAL:                   state_d = S_JAL_WB;
               default:                  state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
         S_RTEXE:  state_d = S_RTWB;
         S_IEXE:   state_d = S_IWB;
         default:  state_d = S_FETCH;
      endcase
   end

   mc_outdec u_outdec (
      .state     (state_q),
      .opcode    (opcode),
      .zero      (zero),
      .mem_rdy   (rdy),
      .ctrl_word (ctrl_word)
   );

   assign ctrl       = ctrl_t'(ctrl_word);
   assign ir_wr      = ctrl.ir_wr;
   assign pc_en      = ctrl.pc_en;
   assign iord       = ctrl.iord;
   assign mem_rd     = ctrl.mem_rd;
   assign mem_wr     = ctrl.mem_wr;
   assign reg_wr     = ctrl.reg_wr;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign ext_op     = ctrl.ext_op;
   assign alu_op     = ctrl.alu_op;
   assign pc_src     = ctrl.pc_src;
   assign illegal_op = ctrl.illegal_op;
   assign state      = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle vector table through a scoreboard, plus
// reset-abort and single-cycle-memory sequences.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic       ir_wr;
      logic       pc_en;
      logic       iord;
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_wr;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] ext_op;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       illegal_op;
   } ctl_t;

   typedef struct {
      logic [5:0] op;
      logic       z;
      logic       rdy;
      logic [3:0] st;
      ctl_t       ctl;
   } vec_t;

   typedef struct {
      logic [3:0] st;
      ctl_t       ctl;
   } exp_t;

   localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                          BEQ = 6'b000100, ORI = 6'b001101, ADDIU = 6'b001001,
                          LUI = 6'b001111, J = 6'b000010, JAL = 6'b000011,
                          BAD = 6'b111111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rst0 = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic [5:0] funct = 6'b100000;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_ready0 = 1'b0;

   logic ir_wr, pc_en, iord, mem_rd, mem_wr, reg_wr, alu_src_a, illegal_op;
   logic [1:0] reg_dst, mem_to_reg, alu_src_b, ext_op, alu_op, pc_src;
   logic [3:0] state;

   logic ir_wr0, pc_en0, iord0, mem_rd0, mem_wr0, reg_wr0, alu_src_a0, illegal_op0;
   logic [1:0] reg_dst0, mem_to_reg0, alu_src_b0, ext_op0, alu_op0, pc_src0;
   logic [3:0] state0;

   ctl_t act;
   assign act = {ir_wr, pc_en, iord, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg,
                 alu_src_a, alu_src_b, ext_op, alu_op, pc_src, illegal_op};

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_WAIT_EN(1), .ST_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .ir_wr(ir_wr), .pc_en(pc_en), .iord(iord),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .ext_op(ext_op), .alu_op(alu_op), .pc_src(pc_src),
      .illegal_op(illegal_op), .state(state)
   );

   multicycle_ctrl #(.MEM_WAIT_EN(0), .ST_W(4)) dut0 (
      .clk(clk), .reset(rst0), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready0), .ir_wr(ir_wr0), .pc_en(pc_en0), .iord(iord0),
      .mem_rd(mem_rd0), .mem_wr(mem_wr0), .reg_wr(reg_wr0), .reg_dst(reg_dst0),
      .mem_to_reg(mem_to_reg0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
      .ext_op(ext_op0), .alu_op(alu_op0), .pc_src(pc_src0),
      .illegal_op(illegal_op0), .state(state0)
   );

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   exp_t exp_q[$];
   int   ir_cnt;
   logic [3:0] rt_seq [4];

   function automatic ctl_t c(input logic ir, pc, io, rd, wr, rw,
                              input logic [1:0] dst, m2r, input logic sa,
                              input logic [1:0] sb, ext, ao, ps, input logic ill);
      c = {ir, pc, io, rd, wr, rw, dst, m2r, sa, sb, ext, ao, ps, ill};
   endfunction

   task automatic add(input logic [5:0] op, input logic z, input logic r,
                      input logic [3:0] st, input ctl_t ctl);
      vec_t v;
      v.op = op; v.z = z; v.rdy = r; v.st = st; v.ctl = ctl;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic cyc(input logic [5:0] op, input logic z, input logic r);
      @(negedge clk);
      opcode = op; zero = z; mem_ready = r;
      #1;
   endtask

   ctl_t F0, F1, DEC, ILL, MADR, MRD, MWB, MWR, REX, RWB, IWB;
   ctl_t IEX_ORI, IEX_ADDIU, IEX_LUI, BR1, BR0, JMP, JALW;

   initial begin
      //          ir pc io rd wr rw dst m2r sa sb ext ao ps ill
      F0        = c(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      F1        = c(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      DEC       = c(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      ILL       = c(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1);
      MADR      = c(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0);
      MRD       = c(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      MWB       = c(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      MWR       = c(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      REX       = c(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0);
      RWB       = c(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      IWB       = c(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      IEX_ORI   = c(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 3, 0, 0);
      IEX_ADDIU = c(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0);
      IEX_LUI   = c(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 3, 0, 0);
      BR1       = c(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
      BR0       = c(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
      JMP       = c(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
      JALW      = c(0, 1, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 2, 0);

      // LW with two stall cycles in FETCH and in MEMRD
      add(LW, 0, 0, 0, F0);  add(LW, 0, 0, 0, F0);  add(LW, 0, 1, 0, F1);
      add(LW, 0, 0, 1, DEC); add(LW, 0, 0, 2, MADR);
      add(LW, 0, 0, 3, MRD); add(LW, 0, 0, 3, MRD); add(LW, 0, 1, 3, MRD);
      add(LW, 0, 0, 4, MWB);
      add(BEQ, 1, 1, 0, F1); add(BEQ, 1, 0, 1, DEC); add(BEQ, 1, 0, 10, BR1);
      add(BEQ, 0, 1, 0, F1); add(BEQ, 0, 0, 1, DEC); add(BEQ, 0, 0, 10, BR0);
      add(ORI, 0, 1, 0, F1);   add(ORI, 0, 0, 1, DEC);   add(ORI, 0, 0, 8, IEX_ORI);     add(ORI, 0, 0, 9, IWB);
      add(ADDIU, 0, 1, 0, F1); add(ADDIU, 0, 0, 1, DEC); add(ADDIU, 0, 0, 8, IEX_ADDIU); add(ADDIU, 0, 0, 9, IWB);
      add(LUI, 0, 1, 0, F1);   add(LUI, 0, 0, 1, DEC);   add(LUI, 0, 0, 8, IEX_LUI);     add(LUI, 0, 0, 9, IWB);
      add(RT, 0, 1, 0, F1);    add(RT, 0, 0, 1, DEC);    add(RT, 0, 0, 6, REX);          add(RT, 0, 0, 7, RWB);
      add(J, 0, 1, 0, F1);     add(J, 0, 0, 1, DEC);     add(J, 0, 0, 11, JMP);
      add(JAL, 0, 1, 0, F1);   add(JAL, 0, 0, 1, DEC);   add(JAL, 0, 0, 12, JALW);
      add(BAD, 0, 1, 0, F1);   add(BAD, 0, 0, 1, ILL);
      add(SW, 0, 1, 0, F1);    add(SW, 0, 0, 1, DEC);    add(SW, 0, 0, 2, MADR);         add(SW, 0, 1, 5, MWR);

      // reset state: FETCH values while reset is held
      #2;
      chk("reset state", state, 0);
      chk("reset ctrl", act, F0);

      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         exp_t e;
         if (i > 0) @(negedge clk);
         opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].rdy;
         e.st = vecs[i].st; e.ctl = vecs[i].ctl;
         exp_q.push_back(e);
         #1;
         e = exp_q.pop_front();
         chk($sformatf("vec%0d state", i), state, e.st);
         chk($sformatf("vec%0d ctrl", i), act, e.ctl);
      end

      // reset while MEMWR is stalled aborts the write
      cyc(SW, 0, 1); chk("sw fetch", state, 0);
      cyc(SW, 0, 0); chk("sw decode", state, 1);
      cyc(SW, 0, 0); chk("sw memadr", state, 2);
      cyc(SW, 0, 0); chk("memwr stall state", state, 5); chk("memwr stall wr", mem_wr, 1);
      cyc(SW, 0, 0); chk("memwr held wr", mem_wr, 1);
      @(negedge clk); reset = 1'b1; #1;
      chk("abort wr", mem_wr, 0);
      chk("abort state", state, 0);
      chk("abort reg_wr", reg_wr, 0);
      @(negedge clk); reset = 1'b0; mem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc(SW, 0, 0);
         chk($sformatf("post-reset wr%0d", k), mem_wr, 0);
         chk($sformatf("post-reset st%0d", k), state, 0);
      end
      cyc(SW, 0, 1); chk("new sw fetch", state, 0);
      cyc(SW, 0, 0); chk("new sw decode", state, 1);
      cyc(SW, 0, 0); chk("new sw memadr wr", mem_wr, 0);
      cyc(SW, 0, 1); chk("new sw memwr", mem_wr, 1);
      cyc(SW, 0, 0); chk("new sw done state", state, 0); chk("new sw done wr", mem_wr, 0);

      // single-cycle memory: back-to-back R-type at a 4-cycle period
      rt_seq[0] = 4'd0; rt_seq[1] = 4'd1; rt_seq[2] = 4'd6; rt_seq[3] = 4'd7;
      ir_cnt = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (k == 0) begin
            rst0 = 1'b0;
            opcode = RT;
            mem_ready0 = 1'b0;
         end
         #1;
         chk($sformatf("rt0 cyc%0d state", k), state0, rt_seq[k % 4]);
         if (ir_wr0) ir_cnt++;
      end
      chk("rt0 ir_wr count", ir_cnt, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
